pe_array_sequencer: RTL

PE_ARRAY_SEQUENCER -- requirements
Module: pe_array_sequencer

---
 rtl/pe_ctrl_pkg.sv | 19 +
 rtl/mod_counter.sv | 27 ++
 rtl/pe_array_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared control definitions for the PE array sequencer: state encoding and
// the skew-flush length of the systolic array.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Cycles needed for the last skewed operand to reach the far corner PE.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 2;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Up-counter with synchronous load-to-zero, enable and a terminal-count flag
// raised when the count equals the supplied last value.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/pe_array_sequencer.sv
// Phase sequencer for a ROWS x COLS systolic PE array: clear, feed k_len
// operand pairs, flush the skew, then drain one accumulator row per handshake.
module pe_array_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    acc_clr,
  output logic                    pe_en,
  output logic [KW-1:0]           rd_addr,
  output logic                    rd_valid,
  output logic [$clog2(ROWS)-1:0] drain_row,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int FL = flush_len(ROWS, COLS);
  localparam int RW = $clog2(ROWS);

  state_t        state, next;
  logic [KW-1:0] klat;
  logic [KW-1:0] last;
  logic [KW-1:0] cnt;
  logic          cnt_ld, cnt_en, tc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      klat  <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        klat <= k_len;
      end
    end
  end

  // One counter serves every timed phase; its terminal value follows the state.
  always_comb begin
    last = '0;
    case (state)
      FEED:    last = klat - KW'(1);
      FLUSH:   last = KW'(FL - 1);
      DRAIN:   last = KW'(ROWS - 1);
      default: last = '0;
    endcase
  end

  always_comb begin
    next   = state;
    cnt_ld = 1'b0;
    cnt_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next   = CLEAR;
          cnt_ld = 1'b1;
        end
      end
      CLEAR: begin
        cnt_ld = 1'b1;
        next   = (klat == '0) ? DONE : FEED;
      end
      FEED: begin
        if (tc) begin
          cnt_ld = 1'b1;
          next   = (FL > 0) ? FLUSH : DRAIN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      FLUSH: begin
        if (tc) begin
          cnt_ld = 1'b1;
          next   = DRAIN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (tc) begin
            next = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  mod_counter #(.W(KW)) u_phase_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_ld),
    .en    (cnt_en),
    .last  (last),
    .count (cnt),
    .tc    (tc)
  );

  // Outputs depend only on registered state and count, never on live inputs.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign acc_clr   = (state == CLEAR);
  assign pe_en     = (state == FEED) || (state == FLUSH);
  assign rd_valid  = (state == FEED);
  assign rd_addr   = rd_valid ? cnt : '0;
  assign out_valid = (state == DRAIN);
  assign drain_row = out_valid ? cnt[RW-1:0] : '0;

endmodule
